// File: rtl/sine_reader.sv
// -----------------------------------------------------------------------------
// sine_reader : direct-digital-synthesis sine sample generator.
//
// Each generate_next request advances a 22-bit phase accumulator by
// step_size. The new phase selects an entry in a quarter-wave sine ROM. The
// quadrant bits fold the address and the sign, which rebuilds the full wave.
// The signed sample appears two clocks after the request edge, together with
// a one-cycle sample_ready pulse.
//
// Ports (sine_reader):
//   clk           : system clock, rising-edge active
//   reset         : asynchronous, active-low reset
//   step_size     : phase increment per request, unsigned 10.10 fixed point
//   generate_next : request strobe, one request per clock edge while high
//   sample_ready  : one-cycle pulse marking a new sample
//   sample        : signed sine sample, holds between updates
//
// Ports (sine_rom):
//   clk    : clock for the registered read
//   addr_i : quarter-wave table address
//   data_o : table entry, registered (one-cycle latency)
// -----------------------------------------------------------------------------

module sine_rom #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int  DEPTH = 1 << ADDR_W;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMPL  = 32767.0;

  logic [DATA_W-1:0] rom_table [DEPTH];

  // Entry k = round(32767 * sin(pi/2 * k / 1024)). Every entry is positive,
  // so adding 0.5 before truncation is a correct round-to-nearest.
  generate
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam real ANGLE = PI / 2.0 * gi / 1024.0;
      localparam int  ENTRY = $rtoi(AMPL * $sin(ANGLE) + 0.5);
      assign rom_table[gi] = DATA_W'(ENTRY);
    end
  endgenerate

  // The read is registered and has no reset, so tools can map the table
  // into block memory.
  always_ff @(posedge clk) begin
    data_o <= rom_table[addr_i];
  end

endmodule


module sine_reader #(
  parameter int PHASE_W  = 22,
  parameter int STEP_W   = 20,
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [STEP_W-1:0]          step_size,
  input  logic                       generate_next,
  output logic                       sample_ready,
  output logic signed [SAMPLE_W-1:0] sample
);

  // Phase layout: [quadrant(2) | address(ADDR_W) | fraction]
  localparam int Q_HI = PHASE_W - 1;
  localparam int Q_LO = PHASE_W - 2;
  localparam int A_HI = PHASE_W - 3;
  localparam int A_LO = PHASE_W - 2 - ADDR_W;

  // ---------------------------------------------------------------------------
  // Stage 0 (request edge): phase accumulate and address fold
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [1:0]         quad_d;
  logic [ADDR_W-1:0]  raw_addr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               neg_q;     // q[1] of the request that is in stage 1
  logic               valid_q;   // stage-1 valid

  always_comb begin
    phase_d = phase_q;
    if (generate_next) begin
      // Zero-extend the step; wrap-around mod 2^PHASE_W is intentional.
      phase_d = phase_q + PHASE_W'(step_size);
    end
    quad_d     = phase_d[Q_HI:Q_LO];
    raw_addr_d = phase_d[A_HI:A_LO];
    // Odd quadrants run the quarter wave backwards. This mirror gives the
    // small asymmetry at quadrant edges (1023-a rather than 1024-a).
    addr_d     = quad_d[0] ? ~raw_addr_d : raw_addr_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      addr_q  <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= generate_next;
      if (generate_next) begin
        addr_q <= addr_d;
        neg_q  <= quad_d[1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: ROM read, with sign and valid delayed to stay aligned
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] rom_data;
  logic                neg2_q;
  logic                valid2_q;

  sine_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (SAMPLE_W)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg2_q   <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      neg2_q   <= neg_q;
      valid2_q <= valid_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sign restore and output registers
  // ---------------------------------------------------------------------------
  logic                       sample_ready_q;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;

  // ROM entries never exceed 32767, so the negation cannot overflow.
  always_comb begin
    sample_d = sample_q;
    if (valid2_q) begin
      sample_d = neg2_q ? $signed(SAMPLE_W'(0) - rom_data) : $signed(rom_data);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q       <= '0;
      sample_ready_q <= 1'b0;
    end else begin
      sample_q       <= sample_d;
      sample_ready_q <= valid2_q;
    end
  end

  assign sample       = sample_q;
  assign sample_ready = sample_ready_q;

endmodule

// File: tb/tb_sine_reader.sv
// -----------------------------------------------------------------------------
// tb_sine_reader : self-checking bench for sine_reader.
// The reference model keeps the phase as a plain integer. It computes each
// sample directly from the sine formula, including the quadrant fold and the
// sign. It then delays the result by two request edges.
// -----------------------------------------------------------------------------
module tb_sine_reader;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [19:0]        step_size = '0;
  logic               generate_next = 1'b0;
  logic               sample_ready;
  logic signed [15:0] sample;

  int checks = 0;
  int failures = 0;

  localparam real PI = 3.14159265358979323846;

  sine_reader dut (
    .clk           (clk),
    .reset         (reset),
    .step_size     (step_size),
    .generate_next (generate_next),
    .sample_ready  (sample_ready),
    .sample        (sample)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_phase;
  bit m_v0, m_v1;
  int m_s0, m_s1;
  bit e_rdy;
  int e_smp;

  function automatic int rom_ref(input int k);
    real x;
    x = 32767.0 * $sin(PI / 2.0 * k / 1024.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic int wave_ref(input int ph);
    int q, a, v;
    q = ph / 1048576;
    a = (ph / 1024) % 1024;
    v = rom_ref((q % 2 == 1) ? 1023 - a : a);
    return (q >= 2) ? -v : v;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_v0 = 0; m_v1 = 0; m_s0 = 0; m_s1 = 0;
    e_rdy = 0; e_smp = 0;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, expv, $time);
    end
  endtask

  // One clock: drive the inputs, advance the model at the edge, then check
  // 1 ns after the edge.
  task automatic cyc(input bit gen, input logic [19:0] st);
    generate_next = gen;
    step_size     = st;
    @(posedge clk);
    if (reset) begin
      e_rdy = m_v1;
      if (m_v1) e_smp = m_s1;
      m_v1 = m_v0; m_s1 = m_s0;
      m_v0 = gen;
      if (gen) begin
        m_phase = (m_phase + int'(st)) % 4194304;
        m_s0 = wave_ref(m_phase);
      end
    end
    #1;
    chk("ready", {31'd0, sample_ready}, {31'd0, e_rdy});
    chk("sample", 32'(sample), 32'(e_smp));
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    model_clear();
    #1;
    chk("rst_ready", {31'd0, sample_ready}, 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int prev, cnt, vmax, vmin, snap, run;

  initial begin
    model_clear();
    // Reset held while generate_next pulses: outputs stay zero.
    for (int i = 0; i < 4; i++) cyc(1'b1, 20'd1024);
    @(negedge clk);
    reset = 1'b1;

    // One request every 101 cycles, step 1024: monotonic rising samples.
    prev = -1; cnt = 0;
    for (int r = 0; r < 500; r++) begin
      for (int c = 0; c < 101; c++) begin
        cyc(c == 0, 20'd1024);
        if (sample_ready) begin
          cnt++;
          if (cnt == 1) chk("first_rom1", 32'(sample), rom_ref(1));
          checks++;
          assert (sample >= 0 && int'(sample) >= prev) else begin
            failures++;
            $error("FAIL mono obs=%0d exp>=%0d", sample, prev);
          end
          prev = int'(sample);
        end
      end
    end
    chk("mono_count", cnt, 500);
    chk("mono_last", prev, rom_ref(500));

    // A full period of 4096 back-to-back requests from phase 0.
    do_reset();
    cnt = 0; vmax = -40000; vmin = 40000;
    for (int i = 0; i < 4098; i++) begin
      cyc(i < 4096, 20'd1024);
      if (sample_ready) begin
        cnt++;
        if (int'(sample) > vmax) vmax = int'(sample);
        if (int'(sample) < vmin) vmin = int'(sample);
        if (cnt < 2048) begin
          checks++;
          assert (sample >= 0) else begin
            failures++; $error("FAIL sign_pos idx=%0d obs=%0d", cnt, sample);
          end
        end else if (cnt < 4096) begin
          checks++;
          assert (sample <= 0) else begin
            failures++; $error("FAIL sign_neg idx=%0d obs=%0d", cnt, sample);
          end
        end
      end
    end
    chk("period_count", cnt, 4096);
    chk("peak", vmax, 32767);
    chk("trough", vmin, -32767);
    chk("wrap_zero", 32'(sample), 32'd0);

    // Step switch 1024 -> 2048. A full 2048-step period returns to the same sample.
    for (int i = 0; i < 12; i++) cyc(i < 10, 20'd1024);
    snap = int'(sample);
    for (int i = 0; i < 2050; i++) cyc(i < 2048, 20'd2048);
    chk("period_2048", 32'(sample), snap);

    // Back-to-back burst of 5 requests.
    cnt = 0; run = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(i >= 2 && i < 7, 20'd1024);
      if (sample_ready) begin cnt++; run = (i == 4 + cnt - 1) ? run + 1 : run; end
    end
    chk("burst_count", cnt, 5);
    chk("burst_aligned", run, 5);

    // Reset one cycle after a request: the in-flight sample is dropped.
    cyc(1'b1, 20'd1024);
    cyc(1'b0, 20'd1024);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 20'd1024);
    cyc(1'b1, 20'd3072);
    cyc(1'b0, 20'd3072);
    cyc(1'b0, 20'd3072);
    chk("post_rst_rom3", 32'(sample), rom_ref(3));

    // Random requests and steps, including step 0.
    for (int i = 0; i < 600; i++) begin
      logic [19:0] st;
      st = ($urandom_range(0, 7) == 0) ? 20'd0 : 20'($urandom);
      cyc(1'($urandom), st);
    end
    cyc(1'b0, 20'd0);
    cyc(1'b0, 20'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
